// File: rtl/switch_pkg.sv
// Shared sizing helpers and register-offset constants for the switch bank.
package switch_pkg;

    // Switch lanes start at halfword 0; the status halfword sits right after them.
    localparam int unsigned LANE_BASE = 0;

    function automatic int unsigned lane_count(input int unsigned sw_width,
                                               input int unsigned data_width);
        return (sw_width + data_width - 1) / data_width;
    endfunction

    function automatic int unsigned status_index(input int unsigned sw_width,
                                                 input int unsigned data_width);
        return LANE_BASE + lane_count(sw_width, data_width);
    endfunction

    function automatic int unsigned deb_cnt_width(input int unsigned cycles);
        return $clog2(cycles) + 1;
    endfunction

endpackage

// File: rtl/switch_debounce.sv
// One switch bit: 2-flop synchronizer, debounce counter and accepted (stable) bit.
// All state updates on the falling clock edge.
module switch_debounce
    import switch_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = 20000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_din,
    output logic o_stable,
    output logic o_change
);

    localparam int unsigned CNT_W = deb_cnt_width(DEB_CYCLES);
    localparam logic [CNT_W-1:0] TERM = CNT_W'(DEB_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;
    logic             w_stable_d;
    logic [CNT_W-1:0] w_cnt_d;
    logic             w_change;

    always_comb begin
        w_stable_d = r_stable;
        w_cnt_d    = r_cnt;
        w_change   = 1'b0;
        if (r_sync2 == r_stable) begin
            w_cnt_d = '0;
        end else if (r_cnt == TERM) begin
            w_stable_d = r_sync2;
            w_cnt_d    = '0;
            w_change   = 1'b1;
        end else begin
            w_cnt_d = r_cnt + 1'b1;
        end
    end

    always_ff @(negedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync1  <= i_din;
            r_sync2  <= r_sync1;
            r_stable <= w_stable_d;
            r_cnt    <= w_cnt_d;
        end
    end

    assign o_stable = r_stable;
    assign o_change = w_change;

endmodule

// File: rtl/switch_bank.sv
// Debounced board-switch bank with halfword CPU read port.
// Optional change-flag interrupt enabled by defining SWITCH_BANK_IRQ_EN.
module switch_bank
    import switch_pkg::*;
#(
    parameter int unsigned SW_WIDTH   = 24,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned DEB_CYCLES = 20000,
    parameter int unsigned ADDR_WIDTH = 3
) (
    input  logic                  switclk,
    input  logic                  switchrst,
    input  logic                  switchctl,
    input  logic                  switchread,
    input  logic [ADDR_WIDTH-1:0] switchaddr,
    input  logic [SW_WIDTH-1:0]   switch_input,
    output logic [DATA_WIDTH-1:0] switchrdata,
    output logic                  switch_irq
);

    localparam int unsigned LANES    = lane_count(SW_WIDTH, DATA_WIDTH);
    localparam int unsigned STATUS_K = status_index(SW_WIDTH, DATA_WIDTH);
    localparam int unsigned PAD_W    = LANES * DATA_WIDTH;

    logic [SW_WIDTH-1:0]   w_stable;
    logic [SW_WIDTH-1:0]   w_change;
    logic [PAD_W-1:0]      w_pad;
    logic [ADDR_WIDTH-2:0] w_k;
    logic                  w_rd;
    logic                  w_status_rd;
    logic [DATA_WIDTH-1:0] w_status;
    logic [DATA_WIDTH-1:0] w_rdata_d;
    logic [DATA_WIDTH-1:0] r_rdata;

    for (genvar g = 0; g < SW_WIDTH; g++) begin : g_bit
        switch_debounce #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_deb (
            .i_clk   (switclk),
            .i_rst   (switchrst),
            .i_din   (switch_input[g]),
            .o_stable(w_stable[g]),
            .o_change(w_change[g])
        );
    end

    assign w_k         = switchaddr[ADDR_WIDTH-1:1];
    assign w_rd        = switchctl && switchread && !switchaddr[0];
    assign w_status_rd = w_rd && (int'(w_k) == int'(STATUS_K));

    always_comb begin
        w_pad               = '0;
        w_pad[SW_WIDTH-1:0] = w_stable;
    end

`ifdef SWITCH_BANK_IRQ_EN
    localparam int unsigned FLAG_PAD_W = (SW_WIDTH > DATA_WIDTH) ? SW_WIDTH : DATA_WIDTH;

    logic [SW_WIDTH-1:0]   r_flags;
    logic [FLAG_PAD_W-1:0] w_flags_pad;
    logic [FLAG_PAD_W-1:0] w_clr_pad;

    always_comb begin
        w_flags_pad               = '0;
        w_flags_pad[SW_WIDTH-1:0] = r_flags;
        w_clr_pad                 = '0;
        if (w_status_rd) begin
            w_clr_pad[DATA_WIDTH-1:0] = '1;
        end
    end

    // Only the readable low halfword of flags is cleared; a same-edge transition wins.
    always_ff @(negedge switclk or posedge switchrst) begin
        if (switchrst) begin
            r_flags <= '0;
        end else begin
            r_flags <= (r_flags & ~w_clr_pad[SW_WIDTH-1:0]) | w_change;
        end
    end

    assign w_status   = w_flags_pad[DATA_WIDTH-1:0];
    assign switch_irq = |r_flags;
`else
    assign w_status   = '0;
    assign switch_irq = 1'b0;
`endif

    always_comb begin
        w_rdata_d = r_rdata;
        if (w_rd) begin
            w_rdata_d = '0;
            for (int i = 0; i < int'(LANES); i++) begin
                if (int'(w_k) == i) begin
                    w_rdata_d = w_pad[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
            if (w_status_rd) begin
                w_rdata_d = w_status;
            end
        end
    end

    always_ff @(negedge switclk or posedge switchrst) begin
        if (switchrst) begin
            r_rdata <= '0;
        end else begin
            r_rdata <= w_rdata_d;
        end
    end

    assign switchrdata = r_rdata;

endmodule

// File: tb/tb_switch_bank.sv
// Scoreboard bench for switch_bank (DEB_CYCLES=8); expectations adapt to SWITCH_BANK_IRQ_EN.
module tb_switch_bank;

`ifdef SWITCH_BANK_IRQ_EN
    localparam bit IRQ = 1'b1;
`else
    localparam bit IRQ = 1'b0;
`endif

    logic        switclk;
    logic        switchrst;
    logic        switchctl;
    logic        switchread;
    logic [2:0]  switchaddr;
    logic [23:0] switch_input;
    logic [15:0] switchrdata;
    logic        switch_irq;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string       name;
        logic [15:0] exp;
    } exp_t;

    exp_t sb_q[$];

    switch_bank #(
        .SW_WIDTH  (24),
        .DATA_WIDTH(16),
        .DEB_CYCLES(8),
        .ADDR_WIDTH(3)
    ) dut (
        .switclk     (switclk),
        .switchrst   (switchrst),
        .switchctl   (switchctl),
        .switchread  (switchread),
        .switchaddr  (switchaddr),
        .switch_input(switch_input),
        .switchrdata (switchrdata),
        .switch_irq  (switch_irq)
    );

    initial switclk = 1'b0;
    always #5 switclk = ~switclk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every read strobe seen on a falling edge yields one registered response.
    always @(negedge switclk) begin
        if (switchctl && switchread && !switchrst) begin
            #1;
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_read: got %h expected none", switchrdata);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check(e.name, switchrdata, e.exp);
            end
        end
    end

    // Drive one read for exactly one falling edge; called at a rising edge.
    task automatic do_read(input string name, input logic [2:0] addr, input logic [15:0] exp);
        exp_t e;
        e.name = name;
        e.exp  = exp;
        sb_q.push_back(e);
        switchaddr = addr;
        switchctl  = 1'b1;
        switchread = 1'b1;
        @(posedge switclk);
        switchctl  = 1'b0;
        switchread = 1'b0;
    endtask

    task automatic wait_edges(input int n);
        repeat (n) @(posedge switclk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        switchrst    = 1'b1;
        switchctl    = 1'b0;
        switchread   = 1'b0;
        switchaddr   = '0;
        switch_input = '0;
        wait_edges(3);
        check("reset_rdata", switchrdata, 16'h0000);
        check("reset_irq", {15'd0, switch_irq}, 16'h0000);
        switchrst = 1'b0;
        wait_edges(2);

        // Short glitch on bit 0 must be rejected.
        switch_input = 24'h000001;
        wait_edges(5);
        switch_input = 24'h000000;
        wait_edges(12);
        do_read("glitch_lane0", 3'd0, 16'h0000);
        check("glitch_irq", {15'd0, switch_irq}, 16'h0000);
        do_read("glitch_status", 3'd4, 16'h0000);

        // Held input on bit 0 accepted.
        switch_input = 24'h000001;
        wait_edges(11);
        do_read("held_lane0", 3'd0, 16'h0001);
        check("held_irq", {15'd0, switch_irq}, {15'd0, IRQ});
        do_read("held_status", 3'd4, IRQ ? 16'h0001 : 16'h0000);
        check("held_irq_clr", {15'd0, switch_irq}, 16'h0000);
        do_read("held_status2", 3'd4, 16'h0000);

        // Toggle bit 3.
        switch_input = 24'h000009;
        wait_edges(11);
        check("bit3_irq", {15'd0, switch_irq}, {15'd0, IRQ});
        do_read("bit3_status", 3'd4, IRQ ? 16'h0008 : 16'h0000);
        check("bit3_irq_clr", {15'd0, switch_irq}, 16'h0000);
        do_read("bit3_status2", 3'd4, 16'h0000);

        // Clear read lands on the same edge as bit 3 falling: flag must survive.
        switch_input = 24'h000001;
        wait_edges(9);
        do_read("race_status", 3'd4, 16'h0000);
        check("race_irq", {15'd0, switch_irq}, {15'd0, IRQ});
        do_read("race_status2", 3'd4, IRQ ? 16'h0008 : 16'h0000);
        check("race_irq_clr", {15'd0, switch_irq}, 16'h0000);

        // Main pattern across both lanes.
        switch_input = 24'hA51234;
        wait_edges(11);
        check("main_irq", {15'd0, switch_irq}, {15'd0, IRQ});
        do_read("main_lane0", 3'd0, 16'h1234);
        do_read("main_lane1", 3'd2, 16'h00A5);
        do_read("odd_addr_hold", 3'd1, 16'h00A5);
        do_read("beyond_status", 3'd6, 16'h0000);
        do_read("main_status", 3'd4, IRQ ? 16'h1235 : 16'h0000);
        check("main_irq_high", {15'd0, switch_irq}, {15'd0, IRQ});

        // Reset while bit 0 is mid-debounce (counter at 5).
        switch_input = 24'hA51235;
        wait_edges(7);
        switchrst = 1'b1;
        #1;
        check("midrst_rdata", switchrdata, 16'h0000);
        check("midrst_irq", {15'd0, switch_irq}, 16'h0000);
        wait_edges(2);
        switchrst = 1'b0;
        wait_edges(9);
        do_read("post_rst_early", 3'd0, 16'h0000);
        do_read("post_rst_lane0", 3'd0, 16'h1235);
        do_read("post_rst_lane1", 3'd2, 16'h00A5);
        check("post_rst_irq", {15'd0, switch_irq}, {15'd0, IRQ});

        wait_edges(3);
        n_checks++;
        if (sb_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
